// File: rtl/m3_ramp_ctrl_pkg.sv
// rtl/m3_ramp_ctrl_pkg.sv - state codes and default length/power constants for the m3 ramp sequencer
package m3_ramp_ctrl_pkg;

  localparam int LEN_W_DEF = 22;
  localparam logic [21:0] LEN_SLOW_DEF  = 22'd400000;
  localparam logic [21:0] LEN_FAST_DEF  = 22'd20000;
  localparam logic [21:0] LEN_INIT_DEF  = 22'd100000;
  localparam logic [21:0] LEN_STEP_DEF  = 22'd1000;
  localparam logic [21:0] RAMP_STEP_DEF = 22'd200;
  localparam int PWR_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAMP     = 3'd1,
    ST_RUN      = 3'd2,
    ST_SPINDOWN = 3'd3,
    ST_BRAKE    = 3'd4
  } m3State_e;

endpackage

// File: rtl/m3_ramp_ctrl_if.sv
// rtl/m3_ramp_ctrl_if.sv - operator command inputs and step-calculator drive outputs of the m3 ramp sequencer
interface m3_ramp_ctrl_if #(parameter int PWR_W = 4);

  logic             m3startI;
  logic             m3forceStopI;
  logic             m3invRotateI;
  logic             m3speedINCi;
  logic             m3speedDECi;
  logic             m3powerINCi;
  logic             m3powerDECi;
  logic             roundTickI;
  logic             m3enO;
  logic [31:0]      dstRoundLenO;
  logic             invRotateO;
  logic [PWR_W-1:0] powerLevelO;
  logic [2:0]       stateO;

  modport master (
    output m3startI, m3forceStopI, m3invRotateI, m3speedINCi, m3speedDECi,
           m3powerINCi, m3powerDECi, roundTickI,
    input  m3enO, dstRoundLenO, invRotateO, powerLevelO, stateO
  );

  modport slave (
    input  m3startI, m3forceStopI, m3invRotateI, m3speedINCi, m3speedDECi,
           m3powerINCi, m3powerDECi, roundTickI,
    output m3enO, dstRoundLenO, invRotateO, powerLevelO, stateO
  );

endinterface

// File: rtl/m3_ramp_ctrl_edge_det.sv
// rtl/m3_ramp_ctrl_edge_det.sv - single-flop rising-edge detector for synchronous level inputs
module m3_ramp_ctrl_edge_det (
  input  logic clkI,
  input  logic nRstI,
  input  logic dI,
  output logic riseO
);

  logic prev;

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) prev <= 1'b0;
    else        prev <= dI;
  end

  assign riseO = dI & ~prev;

endmodule

// File: rtl/m3_ramp_ctrl.sv
// rtl/m3_ramp_ctrl.sv - soft start/stop sequencer feeding the m3 step calculator
// Optional reverse-with-brake behaviour is enabled by defining M3_REVERSE_BRAKE_EN.
module m3_ramp_ctrl
  import m3_ramp_ctrl_pkg::*;
#(
  parameter int               LEN_W     = LEN_W_DEF,
  parameter logic [LEN_W-1:0] LEN_SLOW  = LEN_SLOW_DEF,
  parameter logic [LEN_W-1:0] LEN_FAST  = LEN_FAST_DEF,
  parameter logic [LEN_W-1:0] LEN_INIT  = LEN_INIT_DEF,
  parameter logic [LEN_W-1:0] LEN_STEP  = LEN_STEP_DEF,
  parameter logic [LEN_W-1:0] RAMP_STEP = RAMP_STEP_DEF,
  parameter int               PWR_W     = PWR_W_DEF,
  parameter logic [PWR_W-1:0] PWR_INIT  = PWR_W'(8)
) (
  input  logic           clkI,
  input  logic           nRstI,
  m3_ramp_ctrl_if.slave  bus
);

  logic startRise, spdInc, spdDec, pwrInc, pwrDec;

  m3_ramp_ctrl_edge_det uStart  (.clkI(clkI), .nRstI(nRstI), .dI(bus.m3startI),    .riseO(startRise));
  m3_ramp_ctrl_edge_det uSpdInc (.clkI(clkI), .nRstI(nRstI), .dI(bus.m3speedINCi), .riseO(spdInc));
  m3_ramp_ctrl_edge_det uSpdDec (.clkI(clkI), .nRstI(nRstI), .dI(bus.m3speedDECi), .riseO(spdDec));
  m3_ramp_ctrl_edge_det uPwrInc (.clkI(clkI), .nRstI(nRstI), .dI(bus.m3powerINCi), .riseO(pwrInc));
  m3_ramp_ctrl_edge_det uPwrDec (.clkI(clkI), .nRstI(nRstI), .dI(bus.m3powerDECi), .riseO(pwrDec));

  m3State_e         state;
  logic             enReg, invRot;
  logic [LEN_W-1:0] curLen, targetLen, goal, nextLen;
  logic [PWR_W-1:0] powerLevel;

  // One extra bit so a step past zero or past the width shows up before clamping.
  logic [LEN_W:0] tgtUp, tgtDn, curX, goalX, diffX, stepX, movedX;

  assign tgtUp = {1'b0, targetLen} + {1'b0, LEN_STEP};
  assign tgtDn = {1'b0, targetLen} - {1'b0, LEN_STEP};

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      targetLen <= LEN_INIT;
    end else if (spdInc && !spdDec) begin
      targetLen <= (tgtDn[LEN_W] || tgtDn < {1'b0, LEN_FAST}) ? LEN_FAST : tgtDn[LEN_W-1:0];
    end else if (spdDec && !spdInc) begin
      targetLen <= (tgtUp > {1'b0, LEN_SLOW}) ? LEN_SLOW : tgtUp[LEN_W-1:0];
    end
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI)                                   powerLevel <= PWR_INIT;
    else if (pwrInc && !pwrDec && ~&powerLevel)   powerLevel <= powerLevel + 1'b1;
    else if (pwrDec && !pwrInc && |powerLevel)    powerLevel <= powerLevel - 1'b1;
  end

  assign goal  = (state == ST_SPINDOWN || state == ST_BRAKE) ? LEN_SLOW : targetLen;
  assign curX  = {1'b0, curLen};
  assign goalX = {1'b0, goal};

  always_comb begin
    diffX  = (goalX >= curX) ? goalX - curX : curX - goalX;
    stepX  = (diffX < {1'b0, RAMP_STEP}) ? diffX : {1'b0, RAMP_STEP};
    movedX = (goalX >= curX) ? curX + stepX : curX - stepX;
  end

  assign nextLen = bus.roundTickI ? movedX[LEN_W-1:0] : curLen;

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state  <= ST_IDLE;
      enReg  <= 1'b0;
      curLen <= LEN_SLOW;
      invRot <= 1'b0;
    end else if (bus.m3forceStopI) begin
      state  <= ST_IDLE;
      enReg  <= 1'b0;
      curLen <= LEN_SLOW;
    end else begin
      case (state)
        ST_IDLE: begin
          curLen <= LEN_SLOW;
          invRot <= bus.m3invRotateI;
          if (startRise) begin
            state <= ST_RAMP;
            enReg <= 1'b1;
          end
        end
        ST_RAMP, ST_RUN: begin
          curLen <= nextLen;
          if (!bus.m3startI)                      state <= ST_SPINDOWN;
`ifdef M3_REVERSE_BRAKE_EN
          else if (bus.m3invRotateI != invRot)    state <= ST_BRAKE;
`endif
          else if (nextLen == goal)               state <= ST_RUN;
          else                                    state <= ST_RAMP;
        end
        ST_SPINDOWN: begin
          curLen <= nextLen;
          if (startRise) begin
            state <= ST_RAMP;
          end else if (nextLen == LEN_SLOW) begin
            state <= ST_IDLE;
            enReg <= 1'b0;
          end
        end
`ifdef M3_REVERSE_BRAKE_EN
        ST_BRAKE: begin
          curLen <= nextLen;
          if (!bus.m3startI) begin
            state <= ST_SPINDOWN;
          end else if (nextLen == LEN_SLOW) begin
            invRot <= ~invRot;
            state  <= ST_RAMP;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          enReg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m3enO        = enReg;
  assign bus.dstRoundLenO = {{(32-LEN_W){1'b0}}, curLen};
  assign bus.invRotateO   = invRot;
  assign bus.powerLevelO  = powerLevel;
  assign bus.stateO       = state;

endmodule
